ee201_pb_bounce_gen: RTL and testbench

EE201_PB_BOUNCE_GEN -- requirements
Module: ee201_pb_bounce_gen

---
 rtl/ee201_pb_bounce_gen.sv | 158 +++++++++++++++
 tb/tb_ee201_pb_bounce_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ee201_pb_bounce_gen.sv
// Bouncy push-button waveform generator: LFSR-timed press bounce,
// stable hold, LFSR-timed release bounce, then a one-cycle DONE.
module ee201_pb_bounce_gen #(
   parameter int         N_BOUNCE = 3,
   parameter int         BW       = 3,
   parameter logic [7:0] SEED     = 8'hA5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic        ABORT,
   input  logic [15:0] HOLD_CYCLES,
   output logic        PB,
   output logic        BUSY,
   output logic        DONE
);

   localparam logic [7:0] SEED_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam int SW = (N_BOUNCE < 1) ? 1 : $clog2(2 * N_BOUNCE);
   localparam int SEG_LAST_I = (N_BOUNCE < 1) ? 0 : 2 * N_BOUNCE - 1;
   localparam logic [SW-1:0] SEG_LAST = SW'(SEG_LAST_I);

   typedef enum logic [2:0] {
      IDLE,
      PBOUNCE,
      HOLD,
      RBOUNCE,
      FIN
   } state_t;

   state_t        state, state_n;
   logic [7:0]    lfsr, lfsr_n, lfsr_step;
   logic [BW-1:0] seg_rem, seg_rem_n;
   logic [SW-1:0] seg_idx, seg_idx_n;
   logic [15:0]   hold_len, hold_len_n;
   logic [15:0]   hold_rem, hold_rem_n;
   logic          pb_n, busy_n, done_n;

   // A zero hold request still yields one high cycle.
   function automatic logic [15:0] hold_init(input logic [15:0] h);
      return (h == 16'd0) ? 16'd0 : h - 16'd1;
   endfunction

   assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   always_comb begin
      state_n    = state;
      lfsr_n     = lfsr;
      seg_rem_n  = seg_rem;
      seg_idx_n  = seg_idx;
      hold_len_n = hold_len;
      hold_rem_n = hold_rem;
      pb_n       = PB;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            pb_n = 1'b0;
            if (START && !ABORT) begin
               hold_len_n = HOLD_CYCLES;
               pb_n       = 1'b1;
               if (N_BOUNCE == 0) begin
                  state_n    = HOLD;
                  hold_rem_n = hold_init(HOLD_CYCLES);
               end else begin
                  state_n   = PBOUNCE;
                  seg_idx_n = '0;
                  seg_rem_n = lfsr[BW-1:0];
                  lfsr_n    = lfsr_step;
               end
            end
         end
         PBOUNCE: begin
            if (seg_rem != '0) begin
               seg_rem_n = seg_rem - 1'b1;
            end else if (seg_idx == SEG_LAST) begin
               state_n    = HOLD;
               pb_n       = 1'b1;
               hold_rem_n = hold_init(hold_len);
            end else begin
               seg_idx_n = seg_idx + 1'b1;
               pb_n      = ~PB;
               seg_rem_n = lfsr[BW-1:0];
               lfsr_n    = lfsr_step;
            end
         end
         HOLD: begin
            if (hold_rem != 16'd0) begin
               hold_rem_n = hold_rem - 16'd1;
            end else if (N_BOUNCE == 0) begin
               state_n = FIN;
               pb_n    = 1'b0;
               done_n  = 1'b1;
            end else begin
               state_n   = RBOUNCE;
               pb_n      = 1'b0;
               seg_idx_n = '0;
               seg_rem_n = lfsr[BW-1:0];
               lfsr_n    = lfsr_step;
            end
         end
         RBOUNCE: begin
            if (seg_rem != '0) begin
               seg_rem_n = seg_rem - 1'b1;
            end else if (seg_idx == SEG_LAST) begin
               state_n = FIN;
               pb_n    = 1'b0;
               done_n  = 1'b1;
            end else begin
               seg_idx_n = seg_idx + 1'b1;
               pb_n      = ~PB;
               seg_rem_n = lfsr[BW-1:0];
               lfsr_n    = lfsr_step;
            end
         end
         FIN: begin
            state_n = IDLE;
            pb_n    = 1'b0;
         end
         default: begin
            state_n = IDLE;
            pb_n    = 1'b0;
         end
      endcase
      // Abort drops the waveform but keeps the LFSR where it was.
      if (ABORT && state != IDLE) begin
         state_n = IDLE;
         pb_n    = 1'b0;
         done_n  = 1'b0;
         lfsr_n  = lfsr;
      end
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state    <= IDLE;
         lfsr     <= SEED_INIT;
         seg_rem  <= '0;
         seg_idx  <= '0;
         hold_len <= '0;
         hold_rem <= '0;
         PB       <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         state    <= state_n;
         lfsr     <= lfsr_n;
         seg_rem  <= seg_rem_n;
         seg_idx  <= seg_idx_n;
         hold_len <= hold_len_n;
         hold_rem <= hold_rem_n;
         PB       <= pb_n;
         BUSY     <= busy_n;
         DONE     <= done_n;
      end
   end

endmodule

// File: tb/tb_ee201_pb_bounce_gen.sv
// Scoreboard bench: a segment-list waveform model feeds an expected
// queue; a monitor compares two DUT lanes (N_BOUNCE=0 and 3).
module tb_ee201_pb_bounce_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] hold = 16'd0;
   logic        pb0, busy0, done0;
   logic        pb1, busy1, done1;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [5:0] sb[$];

   ee201_pb_bounce_gen #(.N_BOUNCE(0), .BW(3), .SEED(8'h00)) dut0 (
      .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort),
      .HOLD_CYCLES(hold), .PB(pb0), .BUSY(busy0), .DONE(done0)
   );

   ee201_pb_bounce_gen #(.N_BOUNCE(3), .BW(3), .SEED(8'hA5)) dut1 (
      .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort),
      .HOLD_CYCLES(hold), .PB(pb1), .BUSY(busy1), .DONE(done1)
   );

   always #5 clk = ~clk;

   // Reference model: each waveform is a list of constant-output segments.
   int         nb[2];
   int         bwl[2];
   logic [7:0] seed_m[2];
   logic [7:0] lf[2];
   bit         act[2];
   int         nseg[2];
   int         cs[2];
   int         co[2];
   logic       s_pb[2][16];
   logic       s_bz[2][16];
   logic       s_dn[2][16];
   int         s_len[2][16];
   logic [7:0] s_lf[2][16];

   function automatic logic [7:0] nxt(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   task automatic add_seg(input int l, input logic p, input logic b,
                          input logic d, input int len,
                          input logic [7:0] v);
      s_pb[l][nseg[l]]  = p;
      s_bz[l][nseg[l]]  = b;
      s_dn[l][nseg[l]]  = d;
      s_len[l][nseg[l]] = len;
      s_lf[l][nseg[l]]  = v;
      nseg[l]++;
   endtask

   task automatic build(input int l, input int h);
      logic [7:0] v;
      int len;
      v = lf[l];
      nseg[l] = 0;
      for (int i = 0; i < 2 * nb[l]; i++) begin
         len = (int'(v) % (1 << bwl[l])) + 1;
         add_seg(l, (i % 2 == 0), 1'b1, 1'b0, len, nxt(v));
         v = nxt(v);
      end
      add_seg(l, 1'b1, 1'b1, 1'b0, (h == 0) ? 1 : h, v);
      for (int i = 0; i < 2 * nb[l]; i++) begin
         len = (int'(v) % (1 << bwl[l])) + 1;
         add_seg(l, (i % 2 == 1), 1'b1, 1'b0, len, nxt(v));
         v = nxt(v);
      end
      add_seg(l, 1'b0, 1'b1, 1'b1, 1, v);
      add_seg(l, 1'b0, 1'b0, 1'b0, 1, v);
      cs[l] = 0;
      co[l] = 0;
      act[l] = 1'b1;
   endtask

   task automatic step(input int l, output logic [2:0] e);
      e = 3'b000;
      if (!rst_n) begin
         act[l] = 1'b0;
         lf[l] = seed_m[l];
      end else if (act[l] && abort) begin
         act[l] = 1'b0;
      end else begin
         if (!act[l] && start && !abort) build(l, int'(hold));
         if (act[l]) begin
            e = {s_pb[l][cs[l]], s_bz[l][cs[l]], s_dn[l][cs[l]]};
            if (co[l] == 0) lf[l] = s_lf[l][cs[l]];
            co[l]++;
            if (co[l] == s_len[l][cs[l]]) begin
               cs[l]++;
               co[l] = 0;
               if (cs[l] == nseg[l]) act[l] = 1'b0;
            end
         end
      end
   endtask

   task automatic cycle(input logic s, input logic a, input logic r,
                        input logic [15:0] h);
      logic [2:0] e0, e1;
      @(negedge clk);
      start = s;
      abort = a;
      rst_n = r;
      hold  = h;
      step(0, e0);
      step(1, e1);
      sb.push_back({e0, e1});
      cyc++;
   endtask

   task automatic idle_wait(input int bound);
      for (int i = 0; i < bound && (act[0] || act[1]); i++)
         cycle(1'b0, 1'b0, 1'b1, hold);
      if (act[0] || act[1]) begin
         bad++;
         $display("FAIL idle_wait cyc=%0d still busy after %0d cycles",
                  cyc, bound);
      end
   endtask

   initial begin
      logic [5:0] x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            total += 2;
            if ({pb0, busy0, done0} !== x[5:3]) begin
               bad++;
               $display("FAIL lane0 t=%0t pb/busy/done got=%b%b%b want=%b",
                        $time, pb0, busy0, done0, x[5:3]);
            end
            if ({pb1, busy1, done1} !== x[2:0]) begin
               bad++;
               $display("FAIL lane1 t=%0t pb/busy/done got=%b%b%b want=%b",
                        $time, pb1, busy1, done1, x[2:0]);
            end
         end
      end
   end

   initial begin
      bit ab;
      nb[0] = 0;  bwl[0] = 3; seed_m[0] = 8'h01;
      nb[1] = 3;  bwl[1] = 3; seed_m[1] = 8'hA5;
      for (int l = 0; l < 2; l++) begin
         act[l] = 1'b0;
         lf[l] = seed_m[l];
      end

      repeat (2) cycle(1'b1, 1'b0, 1'b0, 16'd0);
      cycle(1'b0, 1'b0, 1'b1, 16'd5);
      cycle(1'b1, 1'b0, 1'b1, 16'd5);
      idle_wait(500);

      cycle(1'b1, 1'b0, 1'b1, 16'd0);
      cycle(1'b1, 1'b0, 1'b1, 16'd0);
      cycle(1'b0, 1'b0, 1'b1, 16'd0);
      cycle(1'b1, 1'b0, 1'b1, 16'd9);
      idle_wait(500);

      cycle(1'b1, 1'b0, 1'b1, 16'd10);
      for (int i = 0; i < 500; i++) begin
         ab = act[1] && cs[1] == 6 && co[1] == 3;
         cycle(1'b0, ab, 1'b1, 16'd10);
         if (ab) break;
      end
      idle_wait(500);
      cycle(1'b1, 1'b0, 1'b1, 16'd8);
      idle_wait(500);

      cycle(1'b1, 1'b0, 1'b1, 16'd20);
      repeat (10) cycle(1'b0, 1'b0, 1'b1, 16'd20);
      cycle(1'b1, 1'b1, 1'b0, 16'd20);
      cycle(1'b1, 1'b1, 1'b1, 16'd20);
      idle_wait(500);

      repeat (300) cycle(1'b1, 1'b0, 1'b1, 16'($urandom_range(0, 6)));
      idle_wait(500);

      repeat (3000)
         cycle(($urandom % 4) == 0, ($urandom % 60) == 0,
               ($urandom % 400) != 0, 16'($urandom_range(0, 30)));
      idle_wait(500);

      cycle(1'b1, 1'b0, 1'b1, 16'hFFFF);
      idle_wait(70000);
      cycle(1'b0, 1'b0, 1'b1, 16'd0);

      repeat (3) @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
